mem_arbiter: RTL
================

# mem_arbiter

Shares one memory port between the CPU's instruction fetch channel and its data channel. The block sits between `custom_cpu` and the memory/bus interface. It admits at most one outstanding transaction at a time and uses round-robin arbitration. It also counts grants and wait cycles for performance monitoring.

## Interface
- No parameters; address and data are fixed at 32 bits, the strobe at 4 bits.
- `clk` input 1 — system clock; all state updates on the rising edge.
- `rst` input 1 — asynchronous, active-low reset.
- `inst_req_valid` input 1 — instruction fetch request (from CPU `Inst_Req_Valid`).
- `inst_addr` input 32 — fetch address (CPU `PC`).
- `inst_req_ready` output 1 — fetch request accepted.
- `inst_rdata` output 32 — fetched instruction.
- `inst_rdata_valid` output 1 — instruction valid.
- `inst_rdata_ready` input 1 — CPU ready for the instruction.
- `data_rd` input 1 — data read request (CPU `MemRead`).
- `data_wr` input 1 — data write request (CPU `MemWrite`).
- `data_addr` input 32 — data address, word-aligned.
- `data_wdata` input 32 — write data.
- `data_wstrb` input 4 — byte write strobes.
- `data_req_ready` output 1 — data request accepted.
- `data_rdata` output 32 — load data.
- `data_rdata_valid` output 1 — load data valid.
- `data_rdata_ready` input 1 — CPU ready for load data.
- `mem_req_valid` output 1 — downstream request valid.
- `mem_req_ready` input 1 — downstream request accepted.
- `mem_addr` output 32 — downstream address.
- `mem_wen` output 1 — 1 = write, 0 = read.
- `mem_wdata` output 32 — downstream write data.
- `mem_wstrb` output 4 — downstream strobes.
- `mem_rdata` input 32 — downstream read data.
- `mem_rdata_valid` input 1 — downstream read data valid.
- `mem_rdata_ready` output 1 — arbiter ready for read data.
- `cnt_inst_grant` output 32 — number of instruction grants.
- `cnt_data_grant` output 32 — number of data grants.
- `cnt_wait` output 32 — cycles any upstream request waited while the port was busy.

## Operation
- One-hot FSM with six states: IDLE, I_REQ, I_RESP, D_RD_REQ, D_RD_RESP, D_WR_REQ.
- **IDLE:** arbitrate among pending requesters (`inst_req_valid`, `data_rd|data_wr`).
  - Only one pending: grant it.
  - Both pending: grant the one not granted last. `last_grant` resets to inst, so data wins the first tie.
  - Instruction grant → I_REQ. Data read → D_RD_REQ. Data write → D_WR_REQ.
  - Granting updates `last_grant` and increments the matching grant counter.
- **I_REQ / D_RD_REQ / D_WR_REQ:**
  - Drive `mem_req_valid=1` with the granted channel's address.
  - `mem_wen=1`, `mem_wdata=data_wdata` and `mem_wstrb=data_wstrb` only in D_WR_REQ; otherwise 0.
  - The granted channel's `*_req_ready` equals `mem_req_ready`.
  - On handshake: I_REQ → I_RESP, D_RD_REQ → D_RD_RESP, D_WR_REQ → IDLE (writes carry no response).
- **I_RESP / D_RD_RESP:**
  - Route `mem_rdata` and `mem_rdata_valid` to the granted channel.
  - `mem_rdata_ready` equals that channel's `*_rdata_ready`.
  - Return to IDLE on the response handshake.
- Request fields pass through combinationally from the upstream channel. The CPU holds them stable until `*_req_ready`.
- If `data_rd` and `data_wr` are both 1, the request is treated as a read. This is a protocol violation and is checked by an assertion.
- Outputs of the non-granted channel are held at 0. `*_rdata` is 0 outside its RESP state.
- `cnt_wait` increments in every non-IDLE cycle where the non-granted channel has a pending request.
- All counters wrap modulo 2^32.

## Timing
- **Reset:** asserting `rst` low immediately forces IDLE, `last_grant`=inst, and all counters to 0. All valid/ready/wen outputs drop to 0 combinationally; address, data and strobe outputs are 0.
- **Reset mid-transaction:** any in-flight transaction is abandoned; no response is forwarded after reset.
- **Arbitration latency:** one cycle. A request seen in IDLE in cycle n gives `mem_req_valid=1` in cycle n+1.
- **Best-case fetch:** request handshake in cycle n+1 if `mem_req_ready=1`; response no earlier than n+2; IDLE again one cycle after the response handshake.
- **Write:** returns to IDLE the cycle after the handshake and can grant again from there.
- **No zero-cycle grant:** IDLE never drives `mem_req_valid`.
- **Handshake ordering:** `mem_req_valid` stays asserted until `mem_req_ready`. The address stays stable because the requester holds it.
- **Responses outside RESP states:** a `mem_rdata_valid` outside I_RESP/D_RD_RESP is ignored, and `mem_rdata_ready` is 0.

## Test plan
- **Reset:** pulse `rst` low mid-I_RESP with `mem_rdata_valid=1` → `inst_rdata_valid=0` immediately; FSM in IDLE; all counters 0.
- **Single fetch:** `inst_req_valid=1`, `inst_addr=0x0000_0040`, `mem_req_ready=1`, memory returns 0x2402_0005 two cycles later → `mem_addr=0x40` and `mem_wen=0` in cycle 1; `inst_rdata=0x2402_0005` with valid; `cnt_inst_grant=1`.
- **Tie and round-robin:** both channels request every cycle for four transactions → grant order data, inst, data, inst; `cnt_data_grant=2`, `cnt_inst_grant=2`; `cnt_wait>0`.
- **Store:** `data_wr=1`, `data_addr=0x100`, `data_wdata=0xDEAD_BEEF`, `data_wstrb=4'b0011`, `mem_req_ready` held low 3 cycles → `mem_req_valid` high 4 cycles with stable fields; `data_req_ready` pulses once; FSM returns to IDLE; no response is expected.
- **Back-pressure:** in D_RD_RESP, `data_rdata_ready=0` for 2 cycles while `mem_rdata_valid=1` → `mem_rdata_ready=0`; state holds; completes when ready rises.
- **Counter wrap:** preload `cnt_inst_grant=0xFFFF_FFFF` via force, then one fetch → counter reads 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between fetch and data channels
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req_valid,
    input  logic [31:0] inst_addr,
    output logic        inst_req_ready,
    output logic [31:0] inst_rdata,
    output logic        inst_rdata_valid,
    input  logic        inst_rdata_ready,
    input  logic        data_rd,
    input  logic        data_wr,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_wstrb,
    output logic        data_req_ready,
    output logic [31:0] data_rdata,
    output logic        data_rdata_valid,
    input  logic        data_rdata_ready,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdata_valid,
    output logic        mem_rdata_ready,
    output logic [31:0] cnt_inst_grant,
    output logic [31:0] cnt_data_grant,
    output logic [31:0] cnt_wait
);

    typedef enum logic [5:0] {
        IDLE      = 6'b000001,
        I_REQ     = 6'b000010,
        I_RESP    = 6'b000100,
        D_RD_REQ  = 6'b001000,
        D_RD_RESP = 6'b010000,
        D_WR_REQ  = 6'b100000
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;   // 0 = inst, 1 = data
    logic [31:0] cnt_inst_grant_q, cnt_inst_grant_d;
    logic [31:0] cnt_data_grant_q, cnt_data_grant_d;
    logic [31:0] cnt_wait_q, cnt_wait_d;

    logic data_req;
    logic grant_inst;
    logic grant_data;
    logic wait_inc;

    assign data_req = data_rd | data_wr;

    // Arbitration: a lone requester wins; on a tie the channel not granted last wins.
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (state_q == IDLE) begin
            grant_inst = inst_req_valid && (!data_req || last_grant_q);
            grant_data = data_req && !grant_inst;
        end
    end

    // A wait cycle is any busy cycle in which the channel not being served has a request up.
    always_comb begin
        wait_inc = 1'b0;
        case (state_q)
            I_REQ, I_RESP:                  wait_inc = data_req;
            D_RD_REQ, D_RD_RESP, D_WR_REQ:  wait_inc = inst_req_valid;
            default:                        wait_inc = 1'b0;
        endcase
    end

    // Next-state, grant bookkeeping and channel routing; unused channel outputs stay at 0.
    always_comb begin
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        cnt_inst_grant_d = cnt_inst_grant_q;
        cnt_data_grant_d = cnt_data_grant_q;
        cnt_wait_d       = cnt_wait_q + (wait_inc ? 32'd1 : 32'd0);
        inst_req_ready   = 1'b0;
        inst_rdata       = 32'd0;
        inst_rdata_valid = 1'b0;
        data_req_ready   = 1'b0;
        data_rdata       = 32'd0;
        data_rdata_valid = 1'b0;
        mem_req_valid    = 1'b0;
        mem_addr         = 32'd0;
        mem_wen          = 1'b0;
        mem_wdata        = 32'd0;
        mem_wstrb        = 4'd0;
        mem_rdata_ready  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_inst) begin
                    state_d          = I_REQ;
                    last_grant_d     = 1'b0;
                    cnt_inst_grant_d = cnt_inst_grant_q + 32'd1;
                end else if (grant_data) begin
                    // A simultaneous read and write is served as a read.
                    state_d          = data_rd ? D_RD_REQ : D_WR_REQ;
                    last_grant_d     = 1'b1;
                    cnt_data_grant_d = cnt_data_grant_q + 32'd1;
                end
            end
            I_REQ: begin
                mem_req_valid  = 1'b1;
                mem_addr       = inst_addr;
                inst_req_ready = mem_req_ready;
                if (mem_req_ready) state_d = I_RESP;
            end
            I_RESP: begin
                inst_rdata       = mem_rdata;
                inst_rdata_valid = mem_rdata_valid;
                mem_rdata_ready  = inst_rdata_ready;
                if (mem_rdata_valid && inst_rdata_ready) state_d = IDLE;
            end
            D_RD_REQ: begin
                mem_req_valid  = 1'b1;
                mem_addr       = data_addr;
                data_req_ready = mem_req_ready;
                if (mem_req_ready) state_d = D_RD_RESP;
            end
            D_RD_RESP: begin
                data_rdata       = mem_rdata;
                data_rdata_valid = mem_rdata_valid;
                mem_rdata_ready  = data_rdata_ready;
                if (mem_rdata_valid && data_rdata_ready) state_d = IDLE;
            end
            D_WR_REQ: begin
                mem_req_valid  = 1'b1;
                mem_addr       = data_addr;
                mem_wen        = 1'b1;
                mem_wdata      = data_wdata;
                mem_wstrb      = data_wstrb;
                data_req_ready = mem_req_ready;
                if (mem_req_ready) state_d = IDLE;   // writes carry no response
            end
            default: state_d = IDLE;
        endcase
    end

    // State, round-robin pointer and performance counters; reset abandons any transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            last_grant_q     <= 1'b0;
            cnt_inst_grant_q <= 32'd0;
            cnt_data_grant_q <= 32'd0;
            cnt_wait_q       <= 32'd0;
        end else begin
            state_q          <= state_d;
            last_grant_q     <= last_grant_d;
            cnt_inst_grant_q <= cnt_inst_grant_d;
            cnt_data_grant_q <= cnt_data_grant_d;
            cnt_wait_q       <= cnt_wait_d;
        end
    end

    assign cnt_inst_grant = cnt_inst_grant_q;
    assign cnt_data_grant = cnt_data_grant_q;
    assign cnt_wait       = cnt_wait_q;

    // The CPU must never raise a data read and a data write together.
    assert property (@(posedge clk) disable iff (!rst) !(data_rd && data_wr));

endmodule
